// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA capture path: 800x600@72 timing,
// stored-image geometry and the capture state encoding.
package vga_pkg;

  localparam int H_SYNC   = 120;
  localparam int H_BP     = 64;
  localparam int H_ACTIVE = 800;
  localparam int H_TOTAL  = 1040;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 23;
  localparam int V_ACTIVE = 600;
  localparam int V_TOTAL  = 666;

  localparam int IMG_W  = H_ACTIVE / 4;
  localparam int IMG_H  = V_ACTIVE / 4;
  localparam int RGB_W  = 12;
  localparam int ADDR_W = 15;
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/vga_sync_track.sv
// Sync edge detection, pixel/line counters and timing lock for the incoming
// VGA stream. px/py are the coordinates of the pixel being sampled right now.
module vga_sync_track
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pix_valid,
  input  logic              hs,
  input  logic              vs,
  output logic [HCNT_W-1:0] px,
  output logic [VCNT_W-1:0] py,
  output logic              frame_good,
  output logic              lock_fail,
  output logic              locked
);

  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

  logic              hs_act, vs_act, hs_prev, vs_prev;
  logic              hs_edge, vs_edge;
  logic              line_ok, frame_pass, sat, lines_good;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;

  assign hs_act  = (hs == SYNC_POL);
  assign vs_act  = (vs == SYNC_POL);
  assign hs_edge = pix_valid & hs_act & ~hs_prev;
  assign vs_edge = pix_valid & vs_act & ~vs_prev;

  assign line_ok = ({1'b0, hcnt} + 12'd1) == 12'(H_TOTAL);
  assign sat     = pix_valid & ~hs_edge & (hcnt >= HCNT_MAX - 11'd1);

  // An hs edge on the same pixel as the vs edge closes the last line of the
  // frame being judged, so its line check counts toward this frame.
  assign frame_pass = (({1'b0, vcnt} + 11'd1) == 11'(V_TOTAL)) & lines_good
                    & (~hs_edge | line_ok);

  assign frame_good = vs_edge & frame_pass & ~sat;
  assign lock_fail  = (hs_edge & ~line_ok) | (vs_edge & ~frame_pass) | sat;

  assign px = hs_edge ? '0 : ((hcnt == HCNT_MAX) ? hcnt : hcnt + 11'd1);
  assign py = vs_edge ? '0 : (hs_edge ? vcnt + 10'd1 : vcnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      lines_good <= 1'b0;
      locked     <= 1'b0;
    end else if (pix_valid) begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      hcnt    <= px;
      vcnt    <= py;
      if (vs_edge)      lines_good <= 1'b1;
      else if (hs_edge) lines_good <= lines_good & line_ok;
      if (lock_fail)       locked <= 1'b0;
      else if (frame_good) locked <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: tracks input timing and, when armed, stores one frame
// decimated 4:1 in both axes through the VRAM write port.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int IMG_W    = vga_pkg::IMG_W,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pix_valid,
  input  logic              hs,
  input  logic              vs,
  input  logic [RGB_W-1:0]  rgb,
  input  logic              arm,
  output logic [ADDR_W-1:0] waddr,
  output logic [RGB_W-1:0]  wdata,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              locked
);

  localparam logic [HCNT_W-1:0] X0 = HCNT_W'(H_SYNC + H_BP);
  localparam logic [HCNT_W-1:0] X1 = HCNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCNT_W-1:0] Y0 = VCNT_W'(V_SYNC + V_BP);
  localparam logic [VCNT_W-1:0] Y1 = VCNT_W'(V_SYNC + V_BP + V_ACTIVE);

  cap_state_t        state, state_nxt;
  logic [HCNT_W-1:0] px, x;
  logic [VCNT_W-1:0] py, y;
  logic              frame_good, lock_fail, in_win, wr_hit, capturing;
  logic [ADDR_W-1:0] addr_nxt;

  vga_sync_track #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .SYNC_POL (SYNC_POL)
  ) u_track (
    .clk        (clk),
    .rstn       (rstn),
    .pix_valid  (pix_valid),
    .hs         (hs),
    .vs         (vs),
    .px         (px),
    .py         (py),
    .frame_good (frame_good),
    .lock_fail  (lock_fail),
    .locked     (locked)
  );

  assign capturing = (state == CAPTURE);
  assign busy      = (state != IDLE);

  assign x      = px - X0;
  assign y      = py - Y0;
  assign in_win = (px >= X0) && (px < X1) && (py >= Y0) && (py < Y1);
  assign wr_hit = pix_valid & capturing & ~lock_fail & in_win
                & (x[1:0] == 2'b00) & (y[1:0] == 2'b00);

  assign addr_nxt = ADDR_W'(y[VCNT_W-1:2]) * ADDR_W'(IMG_W)
                  + ADDR_W'(x[HCNT_W-1:2]);

  // NOTE: the default assignment first keeps the next-state logic latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = WAIT_VS;
      // Require the lock to survive this vs edge, not just to have existed.
      WAIT_VS: if (frame_good && locked) state_nxt = CAPTURE;
      CAPTURE: if (lock_fail || frame_good) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= wr_hit;
      done  <= capturing & frame_good;
      err   <= capturing & lock_fail;
      if (wr_hit) begin
        waddr <= addr_nxt;
        wdata <= rgb;
      end
    end
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receiving end of the VGA pixel interface driven by our timing/scan-out blocks.
- Samples a 12-bit RGB pixel stream with hs/vs and checks the line/frame timing against the 800x600@72 format.
- On request, captures one frame, downsampled 4:1 in each axis to 200x150, into the 15-bit/12-bit VRAM write port (same port shape as the painter's write side).
- Lets a frame be looped back into VRAM for self-test, or imported from an external source.

Parameters:
- H_SYNC, 120, hs pulse width in pixels
- H_BP, 64, back porch after the hs pulse
- H_ACTIVE, 800, active pixels per line
- H_TOTAL, 1040, pixels per line
- V_SYNC, 6, vs pulse width in lines
- V_BP, 23, back porch lines after the vs pulse
- V_ACTIVE, 600, active lines per frame
- V_TOTAL, 666, lines per frame
- IMG_W, 200, stored image width (H_ACTIVE/4)
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rstn  in  1  asynchronous active-low reset
- pix_valid  in  1  one-cycle strobe: hs/vs/rgb hold a new pixel this cycle
- hs  in  1  horizontal sync (polarity per SYNC_POL)
- vs  in  1  vertical sync (polarity per SYNC_POL)
- rgb  in  12  pixel colour {r[3:0],g[3:0],b[3:0]}
- arm  in  1  capture request, level or pulse, sampled in IDLE
- waddr  out  15  VRAM write address
- wdata  out  12  VRAM write data
- we  out  1  VRAM write enable, one-cycle pulse per stored pixel
- busy  out  1  capture armed or in progress
- done  out  1  one-cycle pulse: full frame stored
- err  out  1  one-cycle pulse: capture aborted because lock was lost
- locked  out  1  input timing matches the parameters

Behaviour:
- Reset is asynchronous and active-low. When asserted: every output is 0, the state machine is IDLE, all counters are 0, and the previous-sync registers read as deasserted.
- Only cycles with pix_valid=1 advance any counter or state. All other cycles hold state, and we=0.
- Sync edge: the asserted level of hs/vs on a valid pixel whose previous valid sample was deasserted.
- hcnt, 11 bits: set to 0 on an hs edge, otherwise +1; saturates at 2047. vcnt, 10 bits: +1 on each hs edge, set to 0 on a vs edge. If both edges occur on the same pixel, the vs edge wins (vcnt=0).
- Line check: on each hs edge, the previous hcnt+1 must equal H_TOTAL.
- Frame check: on each vs edge, the previous vcnt+1 must equal V_TOTAL, and every line in the frame must have passed the line check.
- locked: set at a vs edge that closes a fully good frame. Cleared on any failed line or frame check, or when hcnt saturates.
- Active window: x = hcnt-(H_SYNC+H_BP) in [0,H_ACTIVE) and y = vcnt-(V_SYNC+V_BP) in [0,V_ACTIVE).
- Stored pixel: x[1:0]==0 and y[1:0]==0.
- Write: waddr = (y>>2)*IMG_W + (x>>2), range 0..29999; wdata = rgb. Registered, so we/waddr/wdata appear the cycle after the sampling pix_valid. Exactly 30000 writes per capture.
- State IDLE: busy=0. arm=1 -> WAIT_VS.
- State WAIT_VS: busy=1. A vs edge with locked=1 -> CAPTURE. While unlocked, the block stays in WAIT_VS indefinitely.
- State CAPTURE: busy=1, writes enabled.
  - Next vs edge with the frame check passing: done=1 for one cycle, -> IDLE, busy=0 the same cycle.
  - locked falling (failed line check, frame check or saturation): err=1 for one cycle, -> IDLE, no further writes, done is not pulsed.
- arm is ignored outside IDLE. arm held high re-arms on the cycle after done/err.
- done and err are never asserted together.
- A reset mid-capture abandons the frame immediately. VRAM contents already written are left as they are.

Decomposition:
- Shared package vga_pkg: 800x600@72 timing constants, IMG_W/IMG_H, the capture state enum {IDLE, WAIT_VS, CAPTURE}, and the RGB width.
- One natural sub-module, vga_sync_track: edge detect, hcnt/vcnt, line/frame checks, locked. The top holds the FSM and address generation.

Test Plan:
- Ideal 1040x666 stream, pix_valid every 4th clk, positive sync -> locked=1 at the second vs edge, never before.
- Arm while locked, with rgb = {x[5:2], y[5:2], 4'hA} -> exactly 30000 we pulses. First write waddr=0 with wdata=0x00A; waddr=201 (x=4, y=4) with wdata=0x11A; last write waddr=29999. Then done pulses once, busy=0.
- Arm before lock -> busy=1, no writes until the first vs edge after lock, then a normal capture.
- Shorten one line to 1039 pixels mid-capture -> locked=0, err pulses once, no done, no further we. The block re-locks after one clean frame.
- Assert rstn=0 for 3 clks mid-capture -> outputs 0 immediately (asynchronous). After release the state is IDLE and locked=0 until a full good frame.
- SYNC_POL=0 with inverted sync waveforms -> identical writes; arm pulsed during CAPTURE -> no effect.
